slc3_mem_arbiter: RTL and testbench
===================================

Name: slc3_mem_arbiter

Overview:
- Sequences every access to the shared 16-bit SLC-3 program/data memory and arbitrates it between two requesters: the CPU datapath (MAR/MDR path, driven by the ISDU) and a debug/loader port (switch-driven memory inspect/poke used alongside Run/Continue).
- Generates the memory strobes with a parameterised wait-state count.
- Returns read data and a one-cycle acknowledge to the requester that was served.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
WAIT_CYCLES, 2, extra cycles strobes are held beyond the first access cycle (0 legal)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address (MAR)
cpu_wdata  in  DATA_W  CPU write data (MDR)
cpu_rdata  out  DATA_W  registered read data to CPU
cpu_ack  out  1  one-cycle completion pulse
dbg_req  in  1  debug access request, level, held until dbg_ack
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  registered read data to debug port
dbg_ack  out  1  one-cycle completion pulse
mem_ce_n  out  1  memory chip enable, active-low
mem_oe_n  out  1  memory output enable, active-low
mem_we_n  out  1  memory write enable, active-low
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state is not IDLE
grant  out  2  current owner: 00 none, 01 CPU, 10 debug

Behaviour:
Reset (Reset = 0 at a rising edge):
- mem_ce_n/oe_n/we_n = 1; mem_addr = 0; mem_wdata = 0.
- cpu_ack = dbg_ack = 0; cpu_rdata = dbg_rdata = 0.
- busy = 0; grant = 00; state = IDLE; last_served = DBG, so the CPU wins the first tie.
- Reset asserted mid-access aborts it: strobes deassert at that edge and no ack is issued.

States: IDLE, ACCESS, DONE.

IDLE:
- No request: stay in IDLE.
- Exactly one request: grant it.
- Both requesting: grant the one not equal to last_served (round-robin).
- On grant, at the same edge: latch addr, we and wdata into mem_addr/mem_wdata/internal we; set grant; load wait counter = WAIT_CYCLES; go to ACCESS.

ACCESS:
- Held for WAIT_CYCLES+1 cycles.
- mem_ce_n = 0 throughout.
- Read: mem_oe_n = 0, mem_we_n = 1. Write: mem_we_n = 0, mem_oe_n = 1.
- Counter decrements each cycle; when the counter = 0, go to DONE at the next edge.
- For a read, mem_rdata is captured into the owner's rdata register at that same edge.

DONE (one cycle):
- All strobes = 1; owner's ack = 1; mem_addr/mem_wdata still held.
- Next edge: ack -> 0, grant -> 00, last_served = owner, state -> IDLE.

Timing:
- Latency: request sampled in IDLE at edge 0; ack is high in cycle WAIT_CYCLES+2; for the default, ack is high in cycle 4.
- Minimum spacing between back-to-back grants is WAIT_CYCLES+3 cycles.

Rules and boundary conditions:
- Inputs are sampled only at grant. Later changes to addr/we/wdata, or a dropped req, do not affect the access in flight; ack still pulses.
- A requester must drop req in the cycle after its ack. If req is still high in IDLE, it is treated as a new request and arbitrated normally.
- rdata registers hold their value until the next completed read by the same requester. Writes do not modify rdata.
- A request arriving while busy waits, with no loss. A starved requester is served at most one access later.
- Only one ack may be high in any cycle; cpu_ack and dbg_ack are never high simultaneously.
- WAIT_CYCLES = 0: ACCESS lasts exactly 1 cycle.

Test Plan:
1. Reset = 0 for 2 cycles with cpu_req = 1 -> all strobes 1, acks 0, rdata 0, grant 00, busy 0. After Reset = 1, the CPU is granted at the first edge.
2. CPU read of addr x0003, with memory model returning x1234 -> mem_oe_n low for exactly 3 cycles at addr x0003, cpu_ack high in cycle 4 only, cpu_rdata = x1234 afterwards, dbg_rdata unchanged at 0.
3. Debug write of x00FF to x0010 -> mem_we_n low for 3 cycles, mem_wdata = x00FF, dbg_ack pulses once, and a subsequent CPU read of x0010 returns x00FF.
4. cpu_req and dbg_req held high together for 4 accesses -> grant order CPU, DBG, CPU, DBG; acks alternate; never both high in one cycle.
5. CPU read in flight with cpu_addr changed and cpu_req dropped in the ACCESS cycle -> mem_addr stays at the latched value and cpu_ack still pulses once.
6. Reset = 0 during the second ACCESS cycle of a write -> mem_we_n = 1 at the next edge, no ack, state IDLE. With WAIT_CYCLES = 0 instantiated, ack occurs in cycle 2.

Source files
------------

// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter: sequences accesses to the shared SLC-3 program/data memory
// and arbitrates them round-robin between the CPU datapath and the debug/loader port.
// Ports:
//   Clk, Reset                      clock, synchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack              registered read data, one-cycle completion pulse
//   dbg_req/we/addr/wdata           debug request (level, held until dbg_ack)
//   dbg_rdata, dbg_ack              registered read data, one-cycle completion pulse
//   mem_ce_n/oe_n/we_n              active-low memory strobes
//   mem_addr, mem_wdata, mem_rdata  memory address/data
//   busy, grant                     activity flag, current owner (00 none, 01 CPU, 10 debug)
module slc3_mem_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        grant
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_DBG  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               last_dbg_q, last_dbg_d;
    logic [DATA_W-1:0]  cpu_rdata_d, dbg_rdata_d;
    logic               cpu_ack_d, dbg_ack_d;
    logic               mem_ce_n_d, mem_oe_n_d, mem_we_n_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic [1:0]         grant_d;
    logic               pick_cpu, pick_dbg;

    // Round-robin: on a tie the requester not served last wins.
    assign pick_cpu = cpu_req & (~dbg_req | last_dbg_q);
    assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        last_dbg_d  = last_dbg_q;
        cpu_rdata_d = cpu_rdata;
        dbg_rdata_d = dbg_rdata;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        mem_ce_n_d  = 1'b1;
        mem_oe_n_d  = 1'b1;
        mem_we_n_d  = 1'b1;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        grant_d     = grant;

        unique case (state_q)
            IDLE: begin
                if (pick_cpu || pick_dbg) begin
                    state_d     = ACCESS;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    we_d        = pick_cpu ? cpu_we : dbg_we;
                    mem_addr_d  = pick_cpu ? cpu_addr : dbg_addr;
                    mem_wdata_d = pick_cpu ? cpu_wdata : dbg_wdata;
                    grant_d     = pick_cpu ? GNT_CPU : GNT_DBG;
                    mem_ce_n_d  = 1'b0;
                    mem_oe_n_d  = we_d;
                    mem_we_n_d  = ~we_d;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Last access cycle: release strobes, capture read data, raise ack.
                    state_d = DONE;
                    if (grant == GNT_DBG) begin
                        dbg_ack_d = 1'b1;
                        if (!we_q) dbg_rdata_d = mem_rdata;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    mem_ce_n_d = 1'b0;
                    mem_oe_n_d = we_q;
                    mem_we_n_d = ~we_q;
                end
            end
            DONE: begin
                state_d    = IDLE;
                grant_d    = GNT_NONE;
                last_dbg_d = (grant == GNT_DBG);
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            last_dbg_q <= 1'b1;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            mem_ce_n   <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            grant      <= GNT_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            last_dbg_q <= last_dbg_d;
            cpu_rdata  <= cpu_rdata_d;
            dbg_rdata  <= dbg_rdata_d;
            cpu_ack    <= cpu_ack_d;
            dbg_ack    <= dbg_ack_d;
            mem_ce_n   <= mem_ce_n_d;
            mem_oe_n   <= mem_oe_n_d;
            mem_we_n   <= mem_we_n_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            busy       <= (state_d != IDLE);
            grant      <= grant_d;
        end
    end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Bench for slc3_mem_arbiter: transaction-level model plus directed scenarios,
// and a second instance with WAIT_CYCLES = 0 for the minimum-latency case.
module tb_slc3_mem_arbiter;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, dbg_ack, mem_ce_n, mem_oe_n, mem_we_n, busy;
    logic [1:0]  grant;

    logic        z_cpu_req, z_cpu_we, z_dbg_req, z_dbg_we;
    logic [15:0] z_cpu_addr, z_cpu_wdata, z_dbg_addr, z_dbg_wdata;
    logic [15:0] z_cpu_rdata, z_dbg_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
    logic        z_cpu_ack, z_dbg_ack, z_mem_ce_n, z_mem_oe_n, z_mem_we_n, z_busy;
    logic [1:0]  z_grant;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant(grant)
    );

    slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) u_dut0 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
        .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack),
        .dbg_req(z_dbg_req), .dbg_we(z_dbg_we), .dbg_addr(z_dbg_addr), .dbg_wdata(z_dbg_wdata),
        .dbg_rdata(z_dbg_rdata), .dbg_ack(z_dbg_ack),
        .mem_ce_n(z_mem_ce_n), .mem_oe_n(z_mem_oe_n), .mem_we_n(z_mem_we_n),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata),
        .busy(z_busy), .grant(z_grant)
    );

    // Memory models: a small RAM for the main instance, an address-derived ROM for the other.
    logic [15:0] mem [256];
    assign mem_rdata   = mem[mem_addr[7:0]];
    assign z_mem_rdata = ~z_mem_addr;

    always @(posedge Clk)
        if (!mem_ce_n && !mem_we_n) mem[mem_addr[7:0]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an access occupies W+1 strobe cycles, one ack cycle,
    // then at least one idle cycle before the next grant.
    bit          m_active, m_owner_dbg, m_last_dbg, m_we;
    int          m_age;
    logic [15:0] m_addr, m_wdata, m_cpu_rd, m_dbg_rd;

    always @(posedge Clk) begin
        if (!Reset) begin
            m_active = 0; m_age = 0; m_owner_dbg = 0; m_last_dbg = 1; m_we = 0;
            m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dbg_rd = '0;
        end else if (m_active) begin
            if (m_age == W + 1 && !m_we) begin
                if (m_owner_dbg) m_dbg_rd = mem[m_addr[7:0]];
                else             m_cpu_rd = mem[m_addr[7:0]];
            end
            if (m_age == W + 2) begin
                m_active   = 0;
                m_last_dbg = m_owner_dbg;
            end else begin
                m_age++;
            end
        end else if (cpu_req || dbg_req) begin
            m_owner_dbg = dbg_req && (!cpu_req || !m_last_dbg);
            m_we        = m_owner_dbg ? dbg_we : cpu_we;
            m_addr      = m_owner_dbg ? dbg_addr : cpu_addr;
            m_wdata     = m_owner_dbg ? dbg_wdata : cpu_wdata;
            m_active    = 1;
            m_age       = 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge Clk) begin
        if (chk_en) begin
            automatic bit acc  = m_active && (m_age <= W + 1);
            automatic bit done = m_active && (m_age == W + 2);
            chk("busy",      32'(busy),      32'(m_active));
            chk("grant",     32'(grant),     m_active ? (m_owner_dbg ? 32'd2 : 32'd1) : 32'd0);
            chk("mem_ce_n",  32'(mem_ce_n),  32'(!acc));
            chk("mem_oe_n",  32'(mem_oe_n),  32'(!(acc && !m_we)));
            chk("mem_we_n",  32'(mem_we_n),  32'(!(acc && m_we)));
            chk("cpu_ack",   32'(cpu_ack),   32'(done && !m_owner_dbg));
            chk("dbg_ack",   32'(dbg_ack),   32'(done && m_owner_dbg));
            chk("mem_addr",  32'(mem_addr),  32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
            chk("dbg_rdata", 32'(dbg_rdata), 32'(m_dbg_rd));
            chk("ack_excl",  32'(cpu_ack && dbg_ack), 32'd0);
        end
    end

    // One access on the main instance, starting at a falling edge; req drops when ack is seen.
    task automatic run_access(input bit dbg, input bit we, input logic [15:0] addr,
                              input logic [15:0] wdata, output int ack_at,
                              output int oe_c, output int we_c, output logic [1:0] gnt1);
        ack_at = 0; oe_c = 0; we_c = 0; gnt1 = 2'b00;
        if (dbg) begin
            dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1;
        end
        for (int i = 1; i <= 30; i++) begin
            @(negedge Clk);
            if (i == 1) gnt1 = grant;
            if (!mem_oe_n) oe_c++;
            if (!mem_we_n) we_c++;
            if ((dbg && dbg_ack) || (!dbg && cpu_ack)) begin
                ack_at = i;
                if (dbg) dbg_req = 0; else cpu_req = 0;
                break;
            end
        end
        cpu_req = 0; dbg_req = 0;
    endtask

    int          ack_at, oe_c, we_c, acks;
    logic [1:0]  gnt1;
    int          order [4];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        mem[3] = 16'h1234;
        Reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003; cpu_wdata = 16'h0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 16'h0; dbg_wdata = 16'h0;
        z_cpu_req = 0; z_cpu_we = 0; z_cpu_addr = 16'h0; z_cpu_wdata = 16'h0;
        z_dbg_req = 0; z_dbg_we = 0; z_dbg_addr = 16'h0; z_dbg_wdata = 16'h0;

        // Reset held with a pending CPU request.
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            chk_en = 1;
            chk("rst_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b111);
            chk("rst_acks",    32'({cpu_ack, dbg_ack}), 32'd0);
            chk("rst_rdata",   32'({cpu_rdata, dbg_rdata}), 32'd0);
            chk("rst_grant",   32'({busy, grant}), 32'd0);
        end
        Reset = 1;

        // CPU read of x0003 straight out of reset.
        run_access(0, 0, 16'h0003, 16'h0, ack_at, oe_c, we_c, gnt1);
        chk("t2_grant1", 32'(gnt1), 32'd1);
        chk("t2_ack_at", 32'(ack_at), 32'd4);
        chk("t2_oe_cnt", 32'(oe_c), 32'd3);
        chk("t2_cpu_rd", 32'(cpu_rdata), 32'h1234);
        chk("t2_dbg_rd", 32'(dbg_rdata), 32'h0);
        @(negedge Clk);
        chk("t2_ack_off", 32'(cpu_ack), 32'd0);

        // Debug write then CPU read back.
        run_access(1, 1, 16'h0010, 16'h00FF, ack_at, oe_c, we_c, gnt1);
        chk("t3_ack_at", 32'(ack_at), 32'd4);
        chk("t3_we_cnt", 32'(we_c), 32'd3);
        chk("t3_oe_cnt", 32'(oe_c), 32'd0);
        @(negedge Clk);
        run_access(0, 0, 16'h0010, 16'h0, ack_at, oe_c, we_c, gnt1);
        chk("t3_readback", 32'(cpu_rdata), 32'h00FF);
        chk("t3_dbg_keep", 32'(dbg_rdata), 32'h0);
        @(negedge Clk);
        run_access(1, 0, 16'h0010, 16'h0, ack_at, oe_c, we_c, gnt1);
        chk("t3_dbg_rd", 32'(dbg_rdata), 32'h00FF);
        @(negedge Clk);

        // Both requesting continuously: strict alternation starting with CPU.
        cpu_we = 0; cpu_addr = 16'h0003; dbg_we = 1; dbg_addr = 16'h0020; dbg_wdata = 16'hBEEF;
        cpu_req = 1; dbg_req = 1; acks = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int i = 1; i <= 60 && acks < 4; i++) begin
            @(negedge Clk);
            if (cpu_ack && dbg_ack) chk("t4_both_ack", 32'd1, 32'd0);
            if (cpu_ack) begin order[acks] = 0; acks++; end
            else if (dbg_ack) begin order[acks] = 1; acks++; end
        end
        cpu_req = 0; dbg_req = 0;
        chk("t4_acks", 32'(acks), 32'd4);
        for (int i = 0; i < 4; i++) chk("t4_order", 32'(order[i]), 32'(i % 2));
        @(negedge Clk);

        // Inputs changing after grant do not disturb the access in flight.
        cpu_we = 0; cpu_addr = 16'h0020; cpu_req = 1; acks = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            if (i == 1) begin cpu_addr = 16'h0055; cpu_req = 0; end
            if (i <= 3) chk("t5_addr_held", 32'(mem_addr), 32'h0020);
            if (cpu_ack) acks++;
        end
        chk("t5_ack_once", 32'(acks), 32'd1);
        chk("t5_rdata", 32'(cpu_rdata), 32'hBEEF);

        // Reset in the second ACCESS cycle of a write aborts it.
        cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h7777; cpu_req = 1;
        @(negedge Clk);
        @(negedge Clk);
        chk("t6_we_low", 32'(mem_we_n), 32'd0);
        Reset = 0;
        @(negedge Clk);
        chk("t6_we_n", 32'(mem_we_n), 32'd1);
        chk("t6_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
        chk("t6_idle", 32'({busy, grant}), 32'd0);
        cpu_req = 0;
        Reset = 1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (cpu_ack || dbg_ack) acks++;
        end
        chk("t6_no_ack", 32'(acks), 32'd0);
        run_access(0, 0, 16'h0020, 16'h0, ack_at, oe_c, we_c, gnt1);
        chk("t6_post_rd", 32'(cpu_rdata), 32'hBEEF);
        @(negedge Clk);

        // Zero wait states: single strobe cycle, ack in cycle 2.
        for (int t = 0; t < 2; t++) begin
            z_cpu_we = 1'(t); z_cpu_addr = 16'h0042; z_cpu_wdata = 16'h0BAD; z_cpu_req = 1;
            ack_at = 0; oe_c = 0; we_c = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge Clk);
                if (!z_mem_oe_n) oe_c++;
                if (!z_mem_we_n) we_c++;
                if (z_cpu_ack) begin ack_at = i; z_cpu_req = 0; break; end
            end
            z_cpu_req = 0;
            chk("z_ack_at", 32'(ack_at), 32'd2);
            chk("z_strobe", 32'(t == 0 ? oe_c : we_c), 32'd1);
            chk("z_rdata", 32'(z_cpu_rdata), 32'hFFBD);
            @(negedge Clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
